// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the unidade_controle sequencer: opcodes, ULA codes,
// FSM states and instruction field positions.
package unidade_controle_pkg;

  localparam int INST_W = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ULA_ADD = 3'b000,
    ULA_SUB = 3'b001,
    ULA_MUL = 3'b010,
    ULA_AND = 3'b011,
    ULA_OR  = 3'b100
  } ula_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_EXEC,
    ST_WRITE,
    ST_HALT
  } state_e;

  typedef struct packed {
    ula_op_e    cntrl;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       is_alu;
    logic       is_nop;
    logic       is_halt;
    logic       is_illegal;
  } decoded_t;

endpackage

// File: rtl/inst_decoder.sv
// Combinational instruction decoder: opcode to ULA code and class flags,
// plus extraction of the register address fields.
module inst_decoder
  import unidade_controle_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output decoded_t          dec
);

  logic [3:0] opcode;
  assign opcode = inst[OPC_MSB:OPC_LSB];

  // NOTE: every field gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dec            = '0;
    dec.cntrl      = ULA_ADD;
    dec.rd         = inst[RD_MSB:RD_LSB];
    dec.rs1        = inst[RS1_MSB:RS1_LSB];
    dec.rs2        = inst[RS2_MSB:RS2_LSB];
    case (opcode)
      OP_ADD:  begin dec.cntrl = ULA_ADD; dec.is_alu = 1'b1; end
      OP_SUB:  begin dec.cntrl = ULA_SUB; dec.is_alu = 1'b1; end
      OP_MUL:  begin dec.cntrl = ULA_MUL; dec.is_alu = 1'b1; end
      OP_AND:  begin dec.cntrl = ULA_AND; dec.is_alu = 1'b1; end
      OP_OR:   begin dec.cntrl = ULA_OR;  dec.is_alu = 1'b1; end
      OP_NOP:  dec.is_nop  = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Fetch/wait/decode/execute/write sequencer driving memo_inst, the ULA and the
// register bank; owns the FSM, program counter and instruction register.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int PROG_LEN = 100,
  parameter int PC_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [INST_W-1:0] inst_in,
  output logic [PC_W-1:0]   op_counter,
  output logic [2:0]        cntrl,
  output logic [1:0]        reg1,
  output logic [1:0]        reg2,
  output logic [1:0]        reg3,
  output logic              wr_en,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

  state_e            state, state_nxt;
  logic [INST_W-1:0] ir;
  logic [INST_W-1:0] dec_src;
  decoded_t          dec;

  logic pc_clr, pc_inc, ir_ld, out_ld, illegal_set, illegal_clr;

  // In DECODE the word is still on inst_in; afterwards it lives in ir.
  assign dec_src = (state == ST_DECODE) ? inst_in : ir;

  inst_decoder u_inst_decoder (
    .inst (dec_src),
    .dec  (dec)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pc_clr      = 1'b0;
    pc_inc      = 1'b0;
    ir_ld       = 1'b0;
    out_ld      = 1'b0;
    illegal_set = 1'b0;
    illegal_clr = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt   = ST_FETCH;
          pc_clr      = 1'b1;
          illegal_clr = 1'b1;
        end
      end
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        ir_ld = 1'b1;
        if (dec.is_halt) begin
          state_nxt = ST_HALT;
        end else if (dec.is_alu) begin
          state_nxt = ST_EXEC;
          out_ld    = 1'b1;
        end else if (dec.is_nop || dec.is_illegal) begin
          state_nxt   = ST_FETCH;
          pc_inc      = 1'b1;
          illegal_set = dec.is_illegal;
        end
      end
      ST_EXEC:  state_nxt = ST_WRITE;
      ST_WRITE: begin
        state_nxt = ST_FETCH;
        pc_inc    = 1'b1;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs are loaded on the DECODE->EXEC edge so they are valid for
  // all of EXEC and WRITE and hold afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_counter <= '0;
      ir         <= '0;
      cntrl      <= ULA_ADD;
      reg1       <= '0;
      reg2       <= '0;
      reg3       <= '0;
      wr_en      <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      if (pc_clr)
        op_counter <= '0;
      else if (pc_inc)
        op_counter <= (op_counter == PC_LAST) ? '0 : op_counter + PC_W'(1);
      if (ir_ld) ir <= inst_in;
      if (out_ld) begin
        cntrl <= dec.cntrl;
        reg1  <= dec.rs1;
        reg2  <= dec.rs2;
        reg3  <= dec.rd;
      end
      wr_en <= (state_nxt == ST_WRITE);
      if (illegal_clr)      illegal <= 1'b0;
      else if (illegal_set) illegal <= 1'b1;
    end
  end

  assign busy   = (state != ST_IDLE) && (state != ST_HALT);
  assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_unidade_controle.sv
// Randomized self-checking bench for unidade_controle against a program-level
// model: per-instruction cycle costs, write events, final PC and illegal flag.
module tb_unidade_controle;

  localparam int PROG_LEN  = 100;
  localparam int PC_W      = 16;
  localparam int SMALL_LEN = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic [15:0] inst_in, inst_in_s;

  logic [PC_W-1:0] op_counter, op_counter_s;
  logic [2:0]      cntrl, cntrl_s;
  logic [1:0]      reg1, reg2, reg3, reg1_s, reg2_s, reg3_s;
  logic            wr_en, busy, halted, illegal;
  logic            wr_en_s, busy_s, halted_s, illegal_s;

  logic [15:0] mem   [0:PROG_LEN-1];
  logic [15:0] mem_s [0:SMALL_LEN-1];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0] c;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  wr_t held;
  bit  small_wr_seen = 1'b0;

  always #5 clock = ~clock;

  unidade_controle #(.PROG_LEN(PROG_LEN), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .start(start), .inst_in(inst_in),
    .op_counter(op_counter), .cntrl(cntrl), .reg1(reg1), .reg2(reg2),
    .reg3(reg3), .wr_en(wr_en), .busy(busy), .halted(halted), .illegal(illegal)
  );

  unidade_controle #(.PROG_LEN(SMALL_LEN), .PC_W(PC_W)) dut_small (
    .clock(clock), .reset(reset), .start(start_s), .inst_in(inst_in_s),
    .op_counter(op_counter_s), .cntrl(cntrl_s), .reg1(reg1_s), .reg2(reg2_s),
    .reg3(reg3_s), .wr_en(wr_en_s), .busy(busy_s), .halted(halted_s),
    .illegal(illegal_s)
  );

  // Instruction memories with one cycle of read latency.
  always @(posedge clock) begin
    inst_in   <= mem[op_counter[6:0]];
    inst_in_s <= mem_s[op_counter_s[1:0]];
  end

  always @(negedge clock) begin
    if (wr_en === 1'b1) obs_q.push_back({cntrl, reg3, reg1, reg2});
    if (wr_en_s === 1'b1) small_wr_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Program-level model: walks the program word by word, charging 5 cycles per
  // ALU instruction and 3 per NOP/illegal/HALT, and records register writes.
  task automatic model_run(output int cyc, output int fin_pc, output bit ill);
    int pc;
    logic [15:0] w;
    int op;
    cyc = 0; pc = 0; ill = 1'b0;
    exp_q.delete();
    for (int guard = 0; guard < 1000; guard++) begin
      w  = mem[pc];
      op = int'(w[15:12]);
      cyc += (op <= 4) ? 5 : 3;
      if (op == 15) break;
      if (op <= 4) begin
        held = {3'(op), w[11:10], w[9:8], w[7:6]};
        exp_q.push_back(held);
      end else if (op != 14) begin
        ill = 1'b1;
      end
      pc = (pc + 1) % PROG_LEN;
    end
    fin_pc = pc;
  endtask

  task automatic run_main(input string tag);
    int  exp_cyc, exp_pc, cyc;
    bit  exp_ill, busy_ok;
    wr_t o, e;
    model_run(exp_cyc, exp_pc, exp_ill);
    obs_q.delete();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    cyc = 0;
    busy_ok = 1'b1;
    check({tag, " illegal_clear_on_start"}, 32'(illegal), 32'd0);
    while (halted !== 1'b1 && cyc < 2000) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      start = 1'($urandom_range(0, 1));
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " busy_while_running"}, 32'(busy_ok), 32'd1);
    check({tag, " busy_in_halt"}, 32'(busy), 32'd0);
    check({tag, " final_pc"}, 32'(op_counter), 32'(exp_pc));
    check({tag, " illegal"}, 32'(illegal), 32'(exp_ill));
    check({tag, " write_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " write_fields"}, 32'(o), 32'(e));
    end
    check({tag, " held_outputs"}, 32'({cntrl, reg3, reg1, reg2}), 32'(held));
    check({tag, " wr_en_idle"}, 32'(wr_en), 32'd0);
  endtask

  task automatic load(input logic [15:0] words[$]);
    for (int i = 0; i < PROG_LEN; i++) mem[i] = 16'hF000;
    foreach (words[i]) mem[i] = words[i];
  endtask

  initial begin
    logic [15:0] prog[$];
    int cyc;
    bit seen;
    held = '0;
    for (int i = 0; i < PROG_LEN; i++) mem[i] = 16'hF000;
    for (int i = 0; i < SMALL_LEN; i++) mem_s[i] = 16'hE000;

    repeat (2) @(negedge clock);
    check("rst op_counter", 32'(op_counter), 32'd0);
    check("rst outputs", 32'({cntrl, reg1, reg2, reg3}), 32'd0);
    check("rst flags", 32'({wr_en, busy, halted, illegal}), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle without start", 32'({busy, halted}), 32'd0);

    prog = '{16'h0140, 16'hF000};
    load(prog);
    run_main("add_halt");

    prog = '{16'h1E40, 16'h2B80, 16'h3500, 16'h4A40, 16'hF000};
    load(prog);
    run_main("alu_mix");

    prog = '{16'h9000, 16'hF000};
    load(prog);
    run_main("illegal");

    prog = '{16'hE000, 16'h0140, 16'hF000};
    load(prog);
    run_main("restart_clears");

    for (int t = 0; t < 20; t++) begin
      int n;
      logic [3:0] op;
      prog.delete();
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF) op = 4'hE;
        prog.push_back({op, 12'($urandom)});
      end
      prog.push_back({4'hF, 12'($urandom)});
      load(prog);
      run_main($sformatf("rand%0d", t));
    end

    // Reset asserted mid-WRITE must clear everything asynchronously.
    prog = '{16'h0140, 16'hF000};
    load(prog);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (wr_en !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("reach_write", 32'(wr_en), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_rst wr_en", 32'(wr_en), 32'd0);
    check("async_rst flags", 32'({busy, halted, illegal}), 32'd0);
    check("async_rst outputs", 32'({op_counter, cntrl, reg1, reg2, reg3}), 32'd0);
    held = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    check("post_rst idle", 32'({busy, halted, op_counter}), 32'd0);

    // PC wrap on a 4-word all-NOP program.
    @(negedge clock);
    start_s = 1'b1;
    @(negedge clock);
    start_s = 1'b0;
    for (int k = 0; k < 30; k++) begin
      check($sformatf("wrap pc k=%0d", k), 32'(op_counter_s), 32'((k / 3) % SMALL_LEN));
      check($sformatf("wrap busy k=%0d", k), 32'(busy_s), 32'd1);
      @(negedge clock);
    end
    check("wrap no_writes", 32'(small_wr_seen), 32'd0);
    check("wrap no_illegal", 32'(illegal_s), 32'd0);

    // HALT at the last address must not wrap.
    reset = 1'b0;
    mem_s[SMALL_LEN-1] = 16'hF000;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    start_s = 1'b1;
    @(negedge clock);
    start_s = 1'b0;
    cyc = 0;
    while (halted_s !== 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("last_halt latency", 32'(cyc), 32'd12);
    check("last_halt pc", 32'(op_counter_s), 32'(SMALL_LEN - 1));
    seen = busy_s;
    check("last_halt busy", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
